// File: rtl/jt900h_intc.sv
// Interrupt controller: eight rising-edge sources with per-source enable and
// 3-bit level, highest-level arbitration (lowest index on ties), vector
// generation from a base register and a one-wait-state CPU read port.
module jt900h_intc (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        cs,
  input  logic [3:1]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic [1:0]  we,
  input  logic        rd,
  output logic        busy,
  input  logic [7:0]  src,
  output logic        irq,
  input  logic        irq_ack,
  output logic [2:0]  int_lvl,
  output logic [7:0]  int_addr
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  ena_q, ena_d;
  logic [7:0]  vbase_q, vbase_d;
  logic [7:0]  src_q;
  logic [2:0]  lvl_q [8];
  logic [2:0]  lvl_d [8];
  logic [15:0] dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;
  logic [2:0]  int_lvl_q, int_lvl_d;
  logic [7:0]  int_addr_q, int_addr_d;
  logic [2:0]  sel_q, sel_d;

  logic [7:0]  elig;
  logic        any_elig;
  logic [2:0]  win;
  logic [2:0]  win_lvl;
  logic [7:0]  wr_clr;
  logic [7:0]  ack_clr;
  logic [15:0] rd_data;

  // Eligibility and arbitration; strict '>' keeps the lowest index on ties.
  always_comb begin
    win     = 3'd0;
    win_lvl = 3'd0;
    for (int n = 0; n < 8; n++) begin
      elig[n] = pend_q[n] & ena_q[n] & (lvl_q[n] != 3'd0);
      if (elig[n] && (lvl_q[n] > win_lvl)) begin
        win     = 3'(n);
        win_lvl = lvl_q[n];
      end
    end
    any_elig = |elig;
  end

  // Register read multiplexer; level fields carry a zero in bit 3.
  always_comb begin
    rd_data = 16'h0000;
    case (addr)
      3'd0: rd_data = {8'h00, pend_q};
      3'd1: rd_data = {8'h00, ena_q};
      3'd2: rd_data = {1'b0, lvl_q[3], 1'b0, lvl_q[2], 1'b0, lvl_q[1], 1'b0, lvl_q[0]};
      3'd3: rd_data = {1'b0, lvl_q[7], 1'b0, lvl_q[6], 1'b0, lvl_q[5], 1'b0, lvl_q[4]};
      3'd4: rd_data = {8'h00, vbase_q};
      default: rd_data = 16'h0000;
    endcase
  end

  // Byte-lane register writes; PEND is write-1-to-clear.
  always_comb begin
    ena_d   = ena_q;
    vbase_d = vbase_q;
    lvl_d   = lvl_q;
    wr_clr  = 8'h00;
    if (cs && we[0]) begin
      case (addr)
        3'd0: wr_clr = din[7:0];
        3'd1: ena_d = din[7:0];
        3'd2: begin
          lvl_d[0] = din[2:0];
          lvl_d[1] = din[6:4];
        end
        3'd3: begin
          lvl_d[4] = din[2:0];
          lvl_d[5] = din[6:4];
        end
        3'd4: vbase_d = din[7:0];
        default: ;
      endcase
    end
    if (cs && we[1]) begin
      case (addr)
        3'd2: begin
          lvl_d[2] = din[10:8];
          lvl_d[3] = din[14:12];
        end
        3'd3: begin
          lvl_d[6] = din[10:8];
          lvl_d[7] = din[14:12];
        end
        default: ;
      endcase
    end
  end

  // Read handshake: one busy cycle per accepted read, data latched at accept.
  always_comb begin
    busy_d = 1'b0;
    dout_d = dout_q;
    if (!busy_q && cs && rd) begin
      busy_d = 1'b1;
      dout_d = rd_data;
    end
  end

  // Request FSM next state and presented-request outputs.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    sel_d      = sel_q;
    int_lvl_d  = int_lvl_q;
    int_addr_d = int_addr_q;
    ack_clr    = 8'h00;
    case (state_q)
      StIdle: begin
        if (any_elig) begin
          state_d    = StReq;
          sel_d      = win;
          int_lvl_d  = win_lvl;
          int_addr_d = vbase_q + {3'b000, win, 2'b00};
          irq_d      = 1'b1;
        end
      end
      StReq: begin
        if (irq_ack) begin
          ack_clr[sel_q] = 1'b1;
          irq_d          = 1'b0;
          state_d        = StHold;
        end else if (!elig[sel_q]) begin
          irq_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StHold: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A fresh rising edge wins over any clear in the same cycle.
  always_comb begin
    pend_d = (pend_q & ~(wr_clr | ack_clr)) | (src & ~src_q);
  end

  // State registers: synchronous reset, otherwise update only on cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= 8'h00;
      ena_q      <= 8'h00;
      vbase_q    <= 8'h00;
      src_q      <= 8'h00;
      for (int n = 0; n < 8; n++) lvl_q[n] <= 3'd0;
      dout_q     <= 16'h0000;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      int_lvl_q  <= 3'd0;
      int_addr_q <= 8'h00;
      sel_q      <= 3'd0;
    end else if (cen) begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ena_q      <= ena_d;
      vbase_q    <= vbase_d;
      src_q      <= src;
      lvl_q      <= lvl_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
      int_lvl_q  <= int_lvl_d;
      int_addr_q <= int_addr_d;
      sel_q      <= sel_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign irq      = irq_q;
  assign int_lvl  = int_lvl_q;
  assign int_addr = int_addr_q;

endmodule

// File: tb/tb_jt900h_intc.sv
// Self-checking bench for jt900h_intc against a register/priority model.
module tb_jt900h_intc;

  logic        clk = 1'b0;
  logic        rst, cen, cs, rd, irq_ack;
  logic [3:1]  addr;
  logic [15:0] din, dout;
  logic [1:0]  we;
  logic        busy, irq;
  logic [7:0]  src, int_addr;
  logic [2:0]  int_lvl;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the programmer-visible state.
  logic [7:0] m_pend, m_ena, m_vbase;
  logic [2:0] m_lvl [8];

  jt900h_intc dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cs       (cs),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .we       (we),
    .rd       (rd),
    .busy     (busy),
    .src      (src),
    .irq      (irq),
    .irq_ack  (irq_ack),
    .int_lvl  (int_lvl),
    .int_addr (int_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_pend = 0; m_ena = 0; m_vbase = 0;
    for (int n = 0; n < 8; n++) m_lvl[n] = 0;
  endtask

  task automatic do_reset();
    rst = 1; cen = 1; cs = 0; rd = 0; we = 0; addr = 0; din = 0; src = 0; irq_ack = 0;
    step(); step();
    rst = 0;
    model_clear();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] w);
    cs = 1; addr = a; din = d; we = w;
    step();
    cs = 0; we = 0; din = 0;
    if (cen) begin
      if (w[0]) begin
        case (a)
          3'd0: m_pend = m_pend & ~d[7:0];
          3'd1: m_ena = d[7:0];
          3'd2: begin m_lvl[0] = d[2:0]; m_lvl[1] = d[6:4]; end
          3'd3: begin m_lvl[4] = d[2:0]; m_lvl[5] = d[6:4]; end
          3'd4: m_vbase = d[7:0];
          default: ;
        endcase
      end
      if (w[1]) begin
        if (a == 3'd2) begin m_lvl[2] = d[10:8]; m_lvl[3] = d[14:12]; end
        if (a == 3'd3) begin m_lvl[6] = d[10:8]; m_lvl[7] = d[14:12]; end
      end
    end
  endtask

  task automatic bus_read(input logic [2:0] a, output logic b1, output logic b2,
                          output logic [15:0] d);
    cs = 1; rd = 1; addr = a;
    step();
    b1 = busy;
    cs = 0; rd = 0;
    step();
    b2 = busy;
    d  = dout;
  endtask

  task automatic pulse(input logic [7:0] m);
    src = m; step();
    src = 0; step();
    if (cen) m_pend = m_pend | m;
  endtask

  task automatic do_ack();
    irq_ack = 1; step(); irq_ack = 0;
  endtask

  task automatic wait_irq(input int budget);
    int k = 0;
    while (irq !== 1'b1 && k < budget) begin step(); k++; end
  endtask

  task automatic wait_irq_low(input int budget);
    int k = 0;
    while (irq !== 1'b0 && k < budget) begin step(); k++; end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] v;
    v = 16'h0;
    if (a == 3'd0) v = {8'h0, m_pend};
    if (a == 3'd1) v = {8'h0, m_ena};
    if (a == 3'd2) v = {1'b0, m_lvl[3], 1'b0, m_lvl[2], 1'b0, m_lvl[1], 1'b0, m_lvl[0]};
    if (a == 3'd3) v = {1'b0, m_lvl[7], 1'b0, m_lvl[6], 1'b0, m_lvl[5], 1'b0, m_lvl[4]};
    if (a == 3'd4) v = {8'h0, m_vbase};
    return v;
  endfunction

  // Highest level among eligible sources, then the lowest index holding it.
  function automatic void model_winner(output bit found, output int idx);
    int best;
    best = 0; idx = 0;
    for (int n = 0; n < 8; n++)
      if (m_pend[n] && m_ena[n] && m_lvl[n] != 0 && int'(m_lvl[n]) > best) best = m_lvl[n];
    for (int n = 7; n >= 0; n--)
      if (m_pend[n] && m_ena[n] && int'(m_lvl[n]) == best) idx = n;
    found = (best != 0);
  endfunction

  task automatic test_reset();
    logic b1, b2; logic [15:0] d;
    do_reset();
    n_cmp++;
    if ({irq, busy, dout, int_lvl, int_addr} !== 30'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {irq, busy, dout, int_lvl, int_addr});
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), b1, b2, d);
      n_cmp++;
      if (d !== 16'h0) begin n_err++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
    end
  endtask

  task automatic test_regs_random();
    logic b1, b2; logic [15:0] d;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++)
        bus_write(3'($urandom_range(1, 7)), 16'($urandom), 2'($urandom));
      for (int a = 0; a < 8; a++) begin
        bus_read(3'(a), b1, b2, d);
        n_cmp++;
        if (d !== model_read(3'(a))) begin
          n_err++; $display("FAIL regs_rd%0d: got %h want %h", a, d, model_read(3'(a)));
        end
      end
    end
  endtask

  task automatic test_read_timing();
    logic b1, b2; logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h00A5, 2'b11);
    bus_write(3'd4, 16'h0033, 2'b01);
    bus_read(3'd1, b1, b2, d);
    n_cmp++;
    if ({b1, b2} !== 2'b10) begin n_err++; $display("FAIL read_busy: got %b want 10", {b1, b2}); end
    n_cmp++;
    if (d !== 16'h00A5) begin n_err++; $display("FAIL read_ena: got %h want 00a5", d); end
    bus_write(3'd4, 16'hFF77, 2'b10);
    bus_read(3'd4, b1, b2, d);
    n_cmp++;
    if (d !== 16'h0033) begin n_err++; $display("FAIL vbase_hilane: got %h want 0033", d); end
    step();
    n_cmp++;
    if (dout !== 16'h0033) begin n_err++; $display("FAIL dout_hold: got %h want 0033", dout); end
  endtask

  task automatic test_basic();
    logic b1, b2; logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001, 2'b01);
    bus_write(3'd2, 16'h0003, 2'b11);
    bus_write(3'd4, 16'h0040, 2'b01);
    pulse(8'h01);
    wait_irq(10);
    n_cmp++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd3, 8'h40}) begin
      n_err++; $display("FAIL basic_req: got %b/%0d/%h want 1/3/40", irq, int_lvl, int_addr);
    end
    do_ack();
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL basic_ack_irq: got %b want 0", irq); end
    step();
    n_cmp++;
    if ({irq, int_lvl, int_addr} !== {1'b0, 3'd3, 8'h40}) begin
      n_err++; $display("FAIL basic_hold: got %b/%0d/%h want 0/3/40", irq, int_lvl, int_addr);
    end
    bus_read(3'd0, b1, b2, d);
    n_cmp++;
    if (d !== 16'h0) begin n_err++; $display("FAIL basic_pend: got %h want 0", d); end
  endtask

  task automatic test_tie();
    do_reset();
    bus_write(3'd1, 16'h000C, 2'b01);
    bus_write(3'd2, 16'h5500, 2'b11);
    bus_write(3'd4, 16'h0080, 2'b01);
    pulse(8'h0C);
    wait_irq(10);
    n_cmp++;
    if ({irq, int_addr} !== {1'b1, 8'h88}) begin
      n_err++; $display("FAIL tie_first: got %b/%h want 1/88", irq, int_addr);
    end
    do_ack();
    wait_irq(10);
    n_cmp++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd5, 8'h8C}) begin
      n_err++; $display("FAIL tie_second: got %b/%0d/%h want 1/5/8c", irq, int_lvl, int_addr);
    end
    do_ack();
  endtask

  task automatic test_no_preempt();
    do_reset();
    bus_write(3'd1, 16'h0042, 2'b01);
    bus_write(3'd2, 16'h0020, 2'b11);
    bus_write(3'd3, 16'h0700, 2'b11);
    bus_write(3'd4, 16'h00F0, 2'b01);
    pulse(8'h02);
    wait_irq(10);
    pulse(8'h40);
    step();
    n_cmp++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd2, 8'hF4}) begin
      n_err++; $display("FAIL nopre_stable: got %b/%0d/%h want 1/2/f4", irq, int_lvl, int_addr);
    end
    do_ack();
    wait_irq(10);
    n_cmp++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd7, 8'h08}) begin
      n_err++; $display("FAIL nopre_next: got %b/%0d/%h want 1/7/08", irq, int_lvl, int_addr);
    end
    do_ack();
  endtask

  task automatic test_withdraw();
    logic b1, b2; logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001, 2'b01);
    bus_write(3'd2, 16'h0003, 2'b01);
    pulse(8'h01);
    wait_irq(10);
    bus_write(3'd0, 16'h0001, 2'b01);
    wait_irq_low(5);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL withdraw_irq: got %b want 0", irq); end
    bus_read(3'd0, b1, b2, d);
    n_cmp++;
    if ({irq, d} !== 17'h0) begin n_err++; $display("FAIL withdraw_idle: got %b/%h want 0/0", irq, d); end
    do_ack();
    step();
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL stray_ack: got %b want 0", irq); end
  endtask

  task automatic test_collision();
    logic b1, b2; logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001, 2'b01);
    bus_write(3'd2, 16'h0001, 2'b01);
    pulse(8'h01);
    wait_irq(10);
    src = 8'h01; irq_ack = 1; step(); irq_ack = 0; src = 0;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL coll_ack_irq: got %b want 0", irq); end
    bus_read(3'd0, b1, b2, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL coll_ack_pend: got %h want 0001", d); end
    wait_irq(10);
    do_ack();
    bus_write(3'd1, 16'h0000, 2'b01);
    src = 8'h01;
    bus_write(3'd0, 16'h0001, 2'b01);
    src = 0;
    bus_read(3'd0, b1, b2, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL coll_w1c_pend: got %h want 0001", d); end
  endtask

  task automatic test_cen();
    logic b1, b2; logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001, 2'b01);
    bus_write(3'd2, 16'h0001, 2'b01);
    cen = 0;
    bus_write(3'd1, 16'h0000, 2'b01);
    pulse(8'h01);
    cs = 1; rd = 1; addr = 3'd1; step(); cs = 0; rd = 0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL cen_busy: got %b want 0", busy); end
    cen = 1;
    step(); step();
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL cen_irq: got %b want 0", irq); end
    bus_read(3'd1, b1, b2, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL cen_ena: got %h want 0001", d); end
  endtask

  task automatic test_random_arb();
    bit found; int idx;
    logic b1, b2; logic [15:0] d;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      bus_write(3'd1, 16'($urandom), 2'b01);
      bus_write(3'd2, 16'($urandom), 2'b11);
      bus_write(3'd3, 16'($urandom), 2'b11);
      bus_write(3'd4, 16'($urandom), 2'b01);
      pulse(8'($urandom));
      for (int k = 0; k < 9; k++) begin
        model_winner(found, idx);
        if (!found) begin
          step(); step(); step();
          n_cmp++;
          if (irq !== 1'b0) begin n_err++; $display("FAIL arb_quiet%0d: got %b want 0", r, irq); end
          break;
        end
        wait_irq(10);
        n_cmp++;
        if ({irq, int_lvl, int_addr} !== {1'b1, m_lvl[idx], 8'(m_vbase + 8'(idx * 4))}) begin
          n_err++;
          $display("FAIL arb_req%0d: got %b/%0d/%h want 1/%0d/%h", r, irq, int_lvl, int_addr,
                   m_lvl[idx], 8'(m_vbase + 8'(idx * 4)));
        end
        do_ack();
        m_pend[idx] = 1'b0;
      end
      bus_read(3'd0, b1, b2, d);
      n_cmp++;
      if (d !== {8'h0, m_pend}) begin n_err++; $display("FAIL arb_pend%0d: got %h want %h", r, d, m_pend); end
      bus_write(3'd0, 16'h00FF, 2'b01);
    end
  endtask

  task automatic test_reset_mid();
    logic b1, b2; logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001, 2'b01);
    bus_write(3'd2, 16'h0003, 2'b01);
    bus_write(3'd4, 16'h0010, 2'b01);
    pulse(8'h01);
    wait_irq(10);
    cs = 1; rd = 1; addr = 3'd1; step();
    n_cmp++;
    if ({irq, busy} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre: got %b want 11", {irq, busy}); end
    rst = 1; cs = 0; rd = 0; src = 8'h01;
    step();
    n_cmp++;
    if ({irq, busy, dout, int_lvl, int_addr} !== 30'h0) begin
      n_err++; $display("FAIL rstmid_out: got %h want 0", {irq, busy, dout, int_lvl, int_addr});
    end
    rst = 0;
    model_clear();
    step();
    bus_read(3'd0, b1, b2, d);
    n_cmp++;
    if ({irq, d} !== 17'h00001) begin n_err++; $display("FAIL rstmid_edge: got %b/%h want 0/0001", irq, d); end
    src = 0;
  endtask

  initial begin
    test_reset();
    test_regs_random();
    test_read_timing();
    test_basic();
    test_tie();
    test_no_preempt();
    test_withdraw();
    test_collision();
    test_cen();
    test_random_arb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jt900h_intc.md
JT900H_INTC -- requirements
Module: jt900h_intc

Interface
REQ-001 Clock and reset SHALL be `clk` (in, 1, system clock) and `rst` (in, 1, synchronous, active-high); there is one clock and the reset polarity and synchronicity are fixed.
REQ-002 `cen` in 1: clock enable; all state updates SHALL occur only on `clk` edges with `cen`=1.
REQ-003 `cs` in 1: chip select for register access from the CPU bus.
REQ-004 `addr` in 3 (bits [3:1]): word register select.
REQ-005 `din` in 16: CPU write data.
REQ-006 `dout` out 16: register read data.
REQ-007 `we` in 2: byte-lane write strobes; `we[0]` writes `din[7:0]`, `we[1]` writes `din[15:8]`.
REQ-008 `rd` in 1: read strobe.
REQ-009 `busy` out 1: wait-state request to the CPU.
REQ-010 `src` in 8: interrupt source lines, rising-edge sensitive.
REQ-011 `irq` out 1: interrupt request to the CPU.
REQ-012 `irq_ack` in 1: acknowledge from the CPU.
REQ-013 `int_lvl` out 3: level of the presented request.
REQ-014 `int_addr` out 8: vector of the presented request.

Function
REQ-015 Register map SHALL be as follows; unused bits and addresses 5-7 SHALL read 0, and writes to them SHALL be ignored.
- 0 PEND[7:0]: pending flags; writing 1 to a bit clears it, writing 0 has no effect.
- 1 ENA[7:0]: source enables.
- 2 LVL0: 4-bit fields; bits [2:0] of field n hold the level of source n (n=0..3).
- 3 LVL1: same layout for sources 4..7.
- 4 VBASE[7:0]: vector base.
REQ-016 Byte lanes SHALL be honoured per `we` bit, and a write SHALL complete with zero wait states.
REQ-017 Read timing: `cs`&`rd` with `busy`=0 SHALL raise `busy` for exactly one `cen` cycle; `dout` SHALL be valid on the cycle `busy` returns to 0 and held until the next read.
REQ-018 Edge detection: `src[n]` sampled at `cen`; previous 0 and current 1 SHALL set PEND[n] on the next `cen`, independent of ENA.
REQ-019 Eligible source: PEND[n]&ENA[n] with level != 0; level 0 SHALL mean the source is masked.
REQ-020 Arbitration: the winner SHALL be the highest level; on equal levels the lowest index wins.
REQ-021 FSM states SHALL be IDLE, REQ and HOLD.
REQ-022 IDLE -> REQ when any source is eligible; on that transition the block SHALL latch `sel`=winner, set `int_lvl`=level, `int_addr`=(VBASE + 4*sel) mod 256, and `irq`=1.
REQ-023 In REQ, `int_lvl`, `int_addr` and `sel` SHALL stay stable with no re-arbitration, even if a higher-level source becomes pending.
REQ-024 REQ with `irq_ack`=1 SHALL clear PEND[sel], set `irq`=0, and go to HOLD.
REQ-025 REQ with `sel` no longer eligible (cleared, disabled or level set to 0) and `irq_ack`=0 SHALL withdraw: `irq`=0, go to IDLE.
REQ-026 HOLD SHALL last one `cen` cycle and then go to IDLE, so `irq` is low for at least one `cen` cycle between requests.
REQ-027 A new edge on `src[sel]` in the same cycle as the ack SHALL leave PEND[sel] set; an edge in the same cycle as a write-1-to-clear of the same bit SHALL also leave it set.
REQ-028 `irq_ack` outside REQ SHALL be ignored.
REQ-029 `int_lvl` and `int_addr` SHALL hold their last values when `irq`=0.

Reset
REQ-030 `rst`=1 on a `clk` edge SHALL, regardless of `cen`, zero PEND, ENA, LVL0, LVL1, VBASE, the edge history, `dout`, `busy`, `irq`, `int_lvl` and `int_addr`, and force IDLE.
REQ-031 Reset asserted mid-request or mid-read SHALL abort it with no ack side effects, and the first edge on `src` after reset SHALL require a 0->1 transition relative to the reset history of 0.

Verification
REQ-032 ENA=0x01, LVL0=0x0003, VBASE=0x40; pulse `src[0]` -> `irq`=1, `int_lvl`=3, `int_addr`=0x40; ack -> PEND=0x00, `irq` low for 1 cycle.
REQ-033 ENA=0x0C, LVL0=0x5500 (src2=5, src3=5); pulse `src[2]` and `src[3]` together -> `int_addr`=VBASE+8; after ack, next request `int_addr`=VBASE+12.
REQ-034 In REQ for src1 (level 2), raise src6 (level 7) -> outputs unchanged until ack; then src6 is presented with `int_lvl`=7.
REQ-035 In REQ, write PEND=0x01 for `sel`=0 -> `irq` drops with no ack, FSM returns to IDLE.
REQ-036 Read of addr 1 -> `busy`=1 for one `cen` cycle, then `dout`=ENA; a `we`=2'b10 write to addr 4 leaves VBASE unchanged.
REQ-037 Assert `rst` while `irq`=1 and `busy`=1 -> all outputs 0 on the next edge.
